// File: rtl/hwpe_stream_protocol_monitor.sv
// Passive protocol checker for NB_CHANNELS valid/ready streams.
// Every channel tracks its outstanding offer, checks that the offer stays
// stable until it is accepted, counts beats and stall cycles, and
// records sticky violation flags plus the channel that failed first.
module hwpe_stream_protocol_monitor #(
    parameter int unsigned NB_CHANNELS = 4,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input  logic                                          clk_i,
    input  logic                                          rst_ni,
    input  logic                                          clear_i,
    input  logic                                          enable_i,
    input  logic [NB_CHANNELS-1:0]                        valid_i,
    input  logic [NB_CHANNELS-1:0]                        ready_i,
    input  logic [NB_CHANNELS*DATA_WIDTH-1:0]             data_i,
    input  logic [NB_CHANNELS*DATA_WIDTH/8-1:0]           strb_i,
    output logic [NB_CHANNELS-1:0]                        err_vcr_o,
    output logic [NB_CHANNELS-1:0]                        err_vdr_o,
    output logic                                          err_o,
    output logic [NB_CHANNELS*CNT_WIDTH-1:0]              beat_cnt_o,
    output logic [NB_CHANNELS*CNT_WIDTH-1:0]              stall_cnt_o,
    output logic                                          first_err_valid_o,
    output logic [(NB_CHANNELS > 1 ? $clog2(NB_CHANNELS) : 1)-1:0] first_err_ch_o
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned CH_W       = (NB_CHANNELS > 1) ? $clog2(NB_CHANNELS) : 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } state_e;

    state_e state_q [NB_CHANNELS];
    state_e state_d [NB_CHANNELS];

    logic [NB_CHANNELS-1:0][DATA_WIDTH-1:0] cap_data_q;
    logic [NB_CHANNELS-1:0][STRB_WIDTH-1:0] cap_strb_q;
    logic [NB_CHANNELS-1:0][CNT_WIDTH-1:0]  beat_q;
    logic [NB_CHANNELS-1:0][CNT_WIDTH-1:0]  stall_q;
    logic [NB_CHANNELS-1:0]                 err_vcr_q;
    logic [NB_CHANNELS-1:0]                 err_vdr_q;
    logic                                   first_valid_q;
    logic [CH_W-1:0]                        first_ch_q;

    logic [NB_CHANNELS-1:0] beat_inc;
    logic [NB_CHANNELS-1:0] stall_inc;
    logic [NB_CHANNELS-1:0] capture_en;
    logic [NB_CHANNELS-1:0] vcr_hit;
    logic [NB_CHANNELS-1:0] vdr_hit;
    logic [NB_CHANNELS-1:0] new_err;
    logic [CH_W-1:0]        first_ch_sel;

    // Per-channel state register; clear and reset both return every FSM to IDLE.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int c = 0; c < NB_CHANNELS; c++) state_q[c] <= ST_IDLE;
        end else begin
            // NOTE: state is updated with <= so every register samples pre-edge values.
            for (int c = 0; c < NB_CHANNELS; c++) state_q[c] <= clear_i ? ST_IDLE : state_d[c];
        end
    end

    // Next-state logic: a channel is pending while an offer is valid but not yet taken.
    always_comb begin
        for (int c = 0; c < NB_CHANNELS; c++) begin
            // NOTE: default first so no path leaves state_d unassigned (no latch).
            state_d[c] = state_q[c];
            if (!enable_i) begin
                state_d[c] = ST_IDLE;
            end else begin
                unique case (state_q[c])
                    ST_IDLE: if (valid_i[c] && !ready_i[c]) state_d[c] = ST_PEND;
                    ST_PEND: if (!valid_i[c] || ready_i[c])  state_d[c] = ST_IDLE;
                    default: state_d[c] = ST_IDLE;
                endcase
            end
        end
    end

    // Per-channel events derived from the current state and stream inputs.
    always_comb begin
        beat_inc   = '0;
        stall_inc  = '0;
        capture_en = '0;
        vcr_hit    = '0;
        vdr_hit    = '0;
        for (int c = 0; c < NB_CHANNELS; c++) begin
            if (enable_i) begin
                beat_inc[c]   = valid_i[c] && ready_i[c];
                stall_inc[c]  = valid_i[c] && !ready_i[c];
                capture_en[c] = (state_q[c] == ST_IDLE) && valid_i[c] && !ready_i[c];
                vcr_hit[c]    = (state_q[c] == ST_PEND) && valid_i[c] &&
                                ((data_i[c*DATA_WIDTH +: DATA_WIDTH] != cap_data_q[c]) ||
                                 (strb_i[c*STRB_WIDTH +: STRB_WIDTH] != cap_strb_q[c]));
                vdr_hit[c]    = (state_q[c] == ST_PEND) && !valid_i[c];
            end
        end
    end

    // Flags rising this cycle, and the lowest-index channel among them.
    always_comb begin
        new_err      = (vcr_hit & ~err_vcr_q) | (vdr_hit & ~err_vdr_q);
        first_ch_sel = '0;
        for (int c = NB_CHANNELS - 1; c >= 0; c--) begin
            if (new_err[c]) first_ch_sel = CH_W'(c);
        end
    end

    // Capture of the offered beat, held for as long as the channel stays pending.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            // NOTE: the capture storage is reset so the comparison never sees stale data.
            cap_data_q <= '0;
            cap_strb_q <= '0;
        end else if (clear_i) begin
            cap_data_q <= '0;
            cap_strb_q <= '0;
        end else begin
            for (int c = 0; c < NB_CHANNELS; c++) begin
                if (capture_en[c]) begin
                    cap_data_q[c] <= data_i[c*DATA_WIDTH +: DATA_WIDTH];
                    cap_strb_q[c] <= strb_i[c*STRB_WIDTH +: STRB_WIDTH];
                end
            end
        end
    end

    // Saturating counters, sticky flags and first-error record.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            beat_q        <= '0;
            stall_q       <= '0;
            err_vcr_q     <= '0;
            err_vdr_q     <= '0;
            first_valid_q <= 1'b0;
            first_ch_q    <= '0;
        end else if (clear_i) begin
            beat_q        <= '0;
            stall_q       <= '0;
            err_vcr_q     <= '0;
            err_vdr_q     <= '0;
            first_valid_q <= 1'b0;
            first_ch_q    <= '0;
        end else begin
            for (int c = 0; c < NB_CHANNELS; c++) begin
                if (beat_inc[c] && (beat_q[c] != '1))   beat_q[c]  <= beat_q[c] + CNT_WIDTH'(1);
                if (stall_inc[c] && (stall_q[c] != '1)) stall_q[c] <= stall_q[c] + CNT_WIDTH'(1);
            end
            err_vcr_q <= err_vcr_q | vcr_hit;
            err_vdr_q <= err_vdr_q | vdr_hit;
            if (!first_valid_q && (new_err != '0)) begin
                first_valid_q <= 1'b1;
                first_ch_q    <= first_ch_sel;
            end
        end
    end

    assign err_vcr_o         = err_vcr_q;
    assign err_vdr_o         = err_vdr_q;
    assign err_o             = |{err_vcr_q, err_vdr_q};
    assign beat_cnt_o        = beat_q;
    assign stall_cnt_o       = stall_q;
    assign first_err_valid_o = first_valid_q;
    assign first_err_ch_o    = first_ch_q;

endmodule

// File: doc/hwpe_stream_protocol_monitor.md
HWPE_STREAM_PROTOCOL_MONITOR -- requirements
Module: hwpe_stream_protocol_monitor

Interface
REQ-001 Parameters, one per line (name, default, meaning); all other widths derive from these and SHALL NOT be independent parameters:
- NB_CHANNELS, 4, number of monitored streams, >=1
- DATA_WIDTH, 32, data bits per channel, multiple of 8
- CNT_WIDTH, 16, width of each per-channel counter
REQ-002 Ports, one per line (name, direction, width, meaning), clock and reset first:
- clk_i, in, 1, single clock, rising edge
- rst_ni, in, 1, asynchronous active-low reset
- clear_i, in, 1, synchronous clear of all state, flags and counters
- enable_i, in, 1, monitoring enable
- valid_i, in, NB_CHANNELS, per-channel valid
- ready_i, in, NB_CHANNELS, per-channel ready
- data_i, in, NB_CHANNELS*DATA_WIDTH, channel c at bits [c*DATA_WIDTH +: DATA_WIDTH]
- strb_i, in, NB_CHANNELS*DATA_WIDTH/8, channel c at bits [c*DATA_WIDTH/8 +: DATA_WIDTH/8]
- err_vcr_o, out, NB_CHANNELS, sticky value-change-rule violation per channel
- err_vdr_o, out, NB_CHANNELS, sticky valid-deassert-rule violation per channel
- err_o, out, 1, OR of all err_vcr_o and err_vdr_o bits
- beat_cnt_o, out, NB_CHANNELS*CNT_WIDTH, handshakes per channel
- stall_cnt_o, out, NB_CHANNELS*CNT_WIDTH, valid-and-not-ready cycles per channel
- first_err_valid_o, out, 1, a first error has been latched
- first_err_ch_o, out, max(1,$clog2(NB_CHANNELS)), index of the first failing channel
REQ-003 Every input is sampled only; the block SHALL NOT drive any stream signal.

Function
REQ-004 Each channel SHALL run an independent two-state FSM: IDLE and PEND (valid asserted, handshake outstanding).
REQ-005 IDLE: valid&ready -> stay IDLE, beat+1; valid&~ready -> PEND, capture data_i/strb_i of the channel, stall+1; ~valid -> stay IDLE.
REQ-006 PEND: valid&ready -> IDLE, beat+1; valid&~ready -> stay PEND, stall+1; ~valid -> IDLE, set err_vdr_o[c].
REQ-007 In PEND with valid high, data or strb differing from the captured value SHALL set err_vcr_o[c]; the capture SHALL keep the original value until PEND is left.
REQ-008 A VCR mismatch on the handshake cycle itself (PEND, valid&ready) SHALL also set err_vcr_o[c].
REQ-009 Error flags SHALL be set on the rising edge that ends the offending cycle, and SHALL be visible from the next cycle onwards.
REQ-010 Error flags SHALL be sticky until clear_i or reset.
REQ-011 Counters SHALL saturate at 2^CNT_WIDTH-1 and SHALL NOT wrap.
REQ-012 first_err_valid_o/first_err_ch_o SHALL latch on the first edge at which any flag goes 0->1, and SHALL then hold until clear_i or reset.
REQ-013 If several channels fail on the same edge, the lowest index SHALL win.
REQ-014 enable_i=0: FSMs forced to IDLE, counters and flags hold their values, no new errors are raised; on re-enable each FSM starts from IDLE.
REQ-015 clear_i=1 SHALL take priority over every same-cycle event: all FSMs go to IDLE, and all counters, flags and first-error state go to 0 on that edge.
REQ-016 err_o SHALL be combinational from the registered flags, with no added latency.

Reset
REQ-017 While rst_ni=0, asynchronously: all FSMs IDLE; captures 0; err_vcr_o, err_vdr_o, err_o, beat_cnt_o, stall_cnt_o, first_err_valid_o and first_err_ch_o all 0.
REQ-018 Reset asserted mid-transaction SHALL discard the pending state; after release the monitor SHALL behave as after power-up.

Verification
REQ-019 Ch0 valid=1, data=0xA5, ready low 3 cycles then high -> stall_cnt[0]=3, beat_cnt[0]=1, no errors.
REQ-020 Ch1 valid=1, ready=0, data changes 0x10->0x11 on the 2nd cycle -> err_vcr_o[1]=1 the next cycle; first_err_ch_o=1; err_o=1.
REQ-021 Ch2 valid=1, ready=0, then valid=0 -> err_vdr_o[2]=1; later violation on ch0 -> first_err_ch_o stays 2.
REQ-022 Ch0 and ch3 violate on the same edge -> first_err_ch_o=0; err_vcr_o/err_vdr_o show both bits.
REQ-023 CNT_WIDTH=4, 20 back-to-back handshakes on ch0 -> beat_cnt[0]=15; clear_i asserted in the same cycle as a handshake -> all counters 0.
REQ-024 rst_ni pulsed low mid-PEND with an error already set -> all outputs 0 immediately; after release, a clean handshake counts beat=1 with no error.
